// File: rtl/ez90_pkg.sv
// Shared eZ90 core constants and types used by the rename/commit path.
package ez90_pkg;

    localparam int EZ90_NUM_ARCH = 32;
    localparam int EZ90_NUM_PREG = 128;
    localparam int EZ90_PREG_W   = 7;
    localparam int EZ90_ARCH_W   = 5;

    typedef struct packed {
        logic [EZ90_ARCH_W-1:0] rd;
        logic                   rd_valid;
    } ez90_uop_t;

    typedef struct packed {
        ez90_uop_t              uop;
        logic [EZ90_PREG_W-1:0] prd;
    } ez90_uop_rn_t;

    typedef enum logic {
        RUN,
        REBUILD
    } preg_reclaim_state_e;

endpackage

// File: rtl/preg_fifo.sv
// Circular tag FIFO of arbitrary depth; reset preloads START, START+1, ...
// Caller must not push when full nor pop when empty.
module preg_fifo #(
    parameter int DEPTH = 96,
    parameter int W     = 7,
    parameter int START = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    // Non-power-of-two depths need an explicit wrap rather than overflow.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= W'(START + i);
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= din;
                tail      <= wrap_inc(tail);
            end
            if (pop) head <= wrap_inc(head);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign dout  = mem[head];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/preg_reclaim.sv
// Committed arch->phys map plus physical-register free list; a flush
// rebuilds the free list by scanning every tag against the committed map.
module preg_reclaim
    import ez90_pkg::*;
#(
    parameter int NUM_ARCH = EZ90_NUM_ARCH,
    parameter int NUM_PREG = EZ90_NUM_PREG,
    parameter int PREG_W   = EZ90_PREG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              commit_valid,
    input  ez90_uop_rn_t      commit_uop,
    output logic              commit_ready,
    output logic              alloc_valid,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              alloc_ready,
    output logic              rebuilding
);
    localparam int FL_DEPTH = NUM_PREG - NUM_ARCH;

    preg_reclaim_state_e state, state_n;
    logic [PREG_W-1:0]   rmap [NUM_ARCH];
    logic [PREG_W-1:0]   scan, push_tag, c_prd;
    logic                fl_empty, fl_full, rmap_hit, push;
    logic                commit_fire, alloc_fire, commit_wr;

    assign c_prd        = PREG_W'(commit_uop.prd);
    assign alloc_valid  = (state == RUN) && !fl_empty && !flush;
    assign commit_ready = (state == RUN) && !fl_full && !flush;
    assign rebuilding   = (state == REBUILD);
    assign commit_fire  = commit_valid && commit_ready;
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign commit_wr    = commit_fire && commit_uop.uop.rd_valid;

    always_comb begin
        rmap_hit = 1'b0;
        for (int a = 0; a < NUM_ARCH; a++)
            if (rmap[a] == scan) rmap_hit = 1'b1;
    end

    always_comb begin
        state_n  = state;
        push     = 1'b0;
        push_tag = rmap[commit_uop.uop.rd];
        if (flush) begin
            state_n = REBUILD;
        end else begin
            case (state)
                RUN: push = commit_wr;
                REBUILD: begin
                    // Tags absent from the committed map are free; full guard
                    // only matters if the map holds duplicate tags.
                    push     = !rmap_hit && !fl_full;
                    push_tag = scan;
                    if (scan == PREG_W'(NUM_PREG - 1)) state_n = RUN;
                end
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                scan <= '0;
        else if (flush)            scan <= '0;
        else if (state == REBUILD) scan <= scan + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < NUM_ARCH; a++) rmap[a] <= PREG_W'(a);
        end else if (commit_wr) begin
            rmap[commit_uop.uop.rd] <= c_prd;
        end
    end

    preg_fifo #(
        .DEPTH (FL_DEPTH),
        .W     (PREG_W),
        .START (NUM_ARCH)
    ) u_fl (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .din   (push_tag),
        .pop   (alloc_fire),
        .dout  (alloc_preg),
        .empty (fl_empty),
        .full  (fl_full)
    );

endmodule

// File: tb/tb_preg_reclaim.sv
// Bench for preg_reclaim: free-list model acts as scoreboard of expected
// allocation tags; directed table plus flush/reset sequences.
module tb_preg_reclaim;
    import ez90_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n, flush, commit_valid, commit_ready;
    logic         alloc_valid, alloc_ready, rebuilding;
    logic [6:0]   alloc_preg;
    ez90_uop_rn_t commit_uop;

    always #5 clk = ~clk;

    preg_reclaim dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .commit_valid (commit_valid),
        .commit_uop   (commit_uop),
        .commit_ready (commit_ready),
        .alloc_valid  (alloc_valid),
        .alloc_preg   (alloc_preg),
        .alloc_ready  (alloc_ready),
        .rebuilding   (rebuilding)
    );

    int         tests = 0;
    int         fails = 0;
    logic [6:0] mrmap [32];
    logic [6:0] mfl [$];
    int         mreb;
    logic       m_av, m_cr;

    typedef struct {
        logic       cv;
        logic [4:0] rd;
        logic       rdv;
        logic [6:0] prd;
        logic       ar;
        logic       eav;
        logic       ecr;
        logic [6:0] epreg;
    } vec_t;
    vec_t vt [16];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) mrmap[r] = 7'(r);
        mfl.delete();
        for (int t = 32; t < 128; t++) mfl.push_back(7'(t));
        mreb = 0;
    endfunction

    // Called just after a negedge: drive inputs, then check outputs vs model.
    task automatic drive(input logic fl, input logic cv, input logic [4:0] rd,
                         input logic rdv, input logic [6:0] prd, input logic ar);
        flush = fl;
        commit_valid = cv;
        commit_uop.uop.rd = rd;
        commit_uop.uop.rd_valid = rdv;
        commit_uop.prd = prd;
        alloc_ready = ar;
        #1;
        m_av = (mreb == 0) && (mfl.size() != 0) && !fl;
        m_cr = (mreb == 0) && (mfl.size() != 96) && !fl;
        chk("rebuilding", int'(rebuilding), int'(mreb != 0));
        chk("alloc_valid", int'(alloc_valid), int'(m_av));
        if (mfl.size() != 96) chk("commit_ready", int'(commit_ready), int'(m_cr));
        if (m_av && alloc_valid) chk("alloc_preg", int'(alloc_preg), int'(mfl[0]));
    endtask

    // Apply the clock edge to the model, then move to the next negedge.
    task automatic advance();
        logic hit;
        if (flush) begin
            mreb = 128;
            mfl.delete();
            for (int t = 0; t < 128; t++) begin
                hit = 1'b0;
                for (int r = 0; r < 32; r++) if (mrmap[r] == 7'(t)) hit = 1'b1;
                if (!hit) mfl.push_back(7'(t));
            end
        end else if (mreb > 0) begin
            mreb--;
        end else begin
            if (m_av && alloc_ready) void'(mfl.pop_front());
            if (commit_valid && m_cr && commit_uop.uop.rd_valid) begin
                mfl.push_back(mrmap[commit_uop.uop.rd]);
                mrmap[commit_uop.uop.rd] = commit_uop.prd;
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input logic fl, input logic cv, input logic [4:0] rd,
                        input logic rdv, input logic [6:0] prd, input logic ar);
        drive(fl, cv, rd, rdv, prd, ar);
        advance();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic cv, input logic [4:0] rd, input logic rdv,
                                input logic [6:0] prd, input logic ar, input logic eav,
                                input logic ecr, input logic [6:0] epreg);
        vec_t v;
        v.cv = cv; v.rd = rd; v.rdv = rdv; v.prd = prd; v.ar = ar;
        v.eav = eav; v.ecr = ecr; v.epreg = epreg;
        return v;
    endfunction

    int nreb;

    initial begin
        // Starts with empty free list and identity map.
        vt[0]  = mk(1, 5, 1, 32, 0, 0, 1, 0);
        vt[1]  = mk(0, 0, 0, 0,  0, 1, 1, 5);
        vt[2]  = mk(1, 6, 1, 33, 1, 1, 1, 5);
        vt[3]  = mk(1, 7, 1, 34, 0, 1, 1, 6);
        vt[4]  = mk(1, 8, 1, 35, 0, 1, 1, 6);
        vt[5]  = mk(0, 0, 0, 0,  0, 1, 1, 6);
        vt[6]  = mk(1, 9, 1, 36, 1, 1, 1, 6);
        vt[7]  = mk(1, 10, 0, 99, 0, 1, 1, 7);
        vt[8]  = mk(0, 0, 0, 0,  1, 1, 1, 7);
        vt[9]  = mk(0, 0, 0, 0,  1, 1, 1, 8);
        vt[10] = mk(0, 0, 0, 0,  1, 1, 1, 9);
        vt[11] = mk(1, 0, 1, 37, 0, 0, 1, 0);
        vt[12] = mk(0, 0, 0, 0,  1, 1, 1, 0);
        vt[13] = mk(1, 5, 1, 38, 0, 0, 1, 0);
        vt[14] = mk(0, 0, 0, 0,  1, 1, 1, 32);
        vt[15] = mk(0, 0, 0, 0,  0, 0, 1, 0);

        rst_n = 1'b0; flush = 1'b0; commit_valid = 1'b0; alloc_ready = 1'b0;
        commit_uop = '0;
        #11;
        chk("rst_alloc_valid", int'(alloc_valid), 1);
        chk("rst_alloc_preg", int'(alloc_preg), 32);
        chk("rst_rebuilding", int'(rebuilding), 0);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);

        // Preload drain: 32..127 then empty.
        for (int i = 0; i < 96; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("drained_empty", int'(alloc_valid), 0);

        for (int i = 0; i < 16; i++) begin
            drive(0, vt[i].cv, vt[i].rd, vt[i].rdv, vt[i].prd, vt[i].ar);
            chk($sformatf("vec%0d_alloc_valid", i), int'(alloc_valid), int'(vt[i].eav));
            chk($sformatf("vec%0d_commit_ready", i), int'(commit_ready), int'(vt[i].ecr));
            if (vt[i].eav) chk($sformatf("vec%0d_alloc_preg", i), int'(alloc_preg), int'(vt[i].epreg));
            advance();
        end

        // Flush rebuild after displacing arch 1 and 2.
        pulse_reset();
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 1, 1, 1, 40, 0);
        step(0, 1, 2, 1, 41, 0);
        step(1, 0, 0, 0, 0, 0);
        nreb = 0;
        for (int i = 0; i < 140; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            if (rebuilding) nreb++;
            advance();
        end
        chk("rebuild_cycles", nreb, 128);
        drive(0, 0, 0, 0, 0, 0);
        chk("rebuilt_head", int'(alloc_preg), 1);
        advance();
        for (int i = 0; i < 96; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("rebuilt_count_exhausted", int'(alloc_valid), 0);

        // Flush mid-rebuild restarts the scan.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 1, 50, 1);
        nreb = 0;
        for (int i = 0; i < 140; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            if (rebuilding) nreb++;
            advance();
        end
        chk("rebuild_restart_cycles", nreb, 128);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);

        // Async reset mid-rebuild.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_alloc_valid", int'(alloc_valid), 1);
        chk("async_rst_alloc_preg", int'(alloc_preg), 32);
        chk("async_rst_rebuilding", int'(rebuilding), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
